// File: rtl/mcu_sequencer_if.sv
// -----------------------------------------------------------------------------
// mcu_sequencer_if
//
// Host-side handshake bundle for mcu_sequencer: the instruction push channel
// and the read-result channel.
//
// Signals
//   in_valid   host -> seq : instruction on in_instr is valid
//   in_instr   host -> seq : packed {op[3:0], op0, op1, op2}
//   in_ready   seq -> host : sequencer accepts an instruction this cycle
//   res_valid  seq -> host : res_data holds an unconsumed read result
//   res_data   seq -> host : captured mcu read data
//   res_ready  host -> seq : host consumes the result this cycle
//
// Modports
//   master : host side
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface mcu_sequencer_if #(
    parameter int op_sz  = 32,
    parameter int mem_sz = 4
);
    localparam int IW = 4 + 2 * mem_sz + op_sz;

    logic              in_valid;
    logic [IW-1:0]     in_instr;
    logic              in_ready;
    logic              res_valid;
    logic [op_sz-1:0]  res_data;
    logic              res_ready;

    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mcu_sequencer.sv
// -----------------------------------------------------------------------------
// mcu_sequencer
//
// Buffers host instructions in a small FIFO and issues them to the mcu one per
// cycle through registered op ports. Read results (op 7) are captured into a
// handshaked result register; an invalid opcode halts issue until clr_err.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-low
//   host        mcu_sequencer_if.slave: instruction push + result channel
//   run         1 allows FIFO pops; 0 pauses after the current instruction
//   clr_err     single-cycle pulse that leaves HALT
//   err         sticky invalid-opcode flag
//   err_op      opcode that caused err
//   busy        FIFO non-empty or state not IDLE
//   retired     completed-instruction count, wraps
//   mcu_op/op0/op1/op2   registered drive to the mcu
//   mcu_out     read data from the mcu
//   mcu_op_err  invalid-opcode indication from the mcu
// -----------------------------------------------------------------------------
module mcu_sequencer #(
    parameter int op_sz      = 32,
    parameter int mem_sz     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    mcu_sequencer_if.slave      host,
    input  logic                run,
    input  logic                clr_err,
    output logic                err,
    output logic [3:0]          err_op,
    output logic                busy,
    output logic [15:0]         retired,
    output logic [3:0]          mcu_op,
    output logic [mem_sz-1:0]   mcu_op0,
    output logic [op_sz-1:0]    mcu_op1,
    output logic [mem_sz-1:0]   mcu_op2,
    input  logic [op_sz-1:0]    mcu_out,
    input  logic                mcu_op_err
);

    localparam int IW = 4 + 2 * mem_sz + op_sz;
    localparam int AW = $clog2(FIFO_DEPTH);

    // A read has no side effects, so it doubles as the idle command.
    localparam logic [3:0] OP_READ = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state, state_n;

    // ---------------------------------------------------------------------
    // Instruction FIFO. Pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate count.
    // ---------------------------------------------------------------------
    logic [IW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [IW-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = host.in_valid && host.in_ready;
    assign head  = fifo_mem[rd_ptr[AW-1:0]];

    // NOTE: FIFO storage is deliberately not reset; the pointers alone decide
    // which entries are live, and leaving the array reset-free lets it map to
    // plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= host.in_instr;
        end
    end

    // ---------------------------------------------------------------------
    // Result register
    // ---------------------------------------------------------------------
    logic             res_valid;
    logic [op_sz-1:0] res_data;

    assign host.res_valid = res_valid;
    assign host.res_data  = res_data;
    assign host.in_ready  = !full && (state != S_HALT);
    assign busy           = !empty || (state != S_IDLE);

    // ---------------------------------------------------------------------
    // Next-state / control decode
    // ---------------------------------------------------------------------
    logic load_fifo, load_nop, capture, retire, set_err;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        load_fifo = 1'b0;
        load_nop  = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        set_err   = 1'b0;

        case (state)
            S_IDLE: begin
                if (run && !empty) begin
                    pop       = 1'b1;
                    load_fifo = 1'b1;
                    state_n   = S_EXEC;
                end
            end

            S_EXEC: begin
                if (mcu_op_err) begin
                    set_err  = 1'b1;
                    load_nop = 1'b1;
                    state_n  = S_HALT;
                end else if (mcu_op == OP_READ && res_valid && !host.res_ready) begin
                    // Result register still occupied: keep re-issuing the
                    // read, which is harmless because reads are idempotent.
                end else begin
                    capture = (mcu_op == OP_READ);
                    retire  = 1'b1;
                    if (run && !empty) begin
                        pop       = 1'b1;
                        load_fifo = 1'b1;
                    end else begin
                        load_nop = 1'b1;
                        state_n  = S_IDLE;
                    end
                end
            end

            S_HALT: begin
                if (clr_err) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                load_nop = 1'b1;
                state_n  = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, pointers, issue register, result register, counters
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mcu_op    <= OP_READ;
            mcu_op0   <= '0;
            mcu_op1   <= '0;
            mcu_op2   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            retired   <= '0;
            err       <= 1'b0;
            err_op    <= '0;
        end else begin
            state <= state_n;

            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end

            if (load_fifo) begin
                mcu_op  <= head[IW-1 -: 4];
                mcu_op0 <= head[IW-5 -: mem_sz];
                mcu_op1 <= head[mem_sz +: op_sz];
                mcu_op2 <= head[mem_sz-1:0];
            end else if (load_nop) begin
                mcu_op  <= OP_READ;
                mcu_op0 <= '0;
                mcu_op1 <= '0;
                mcu_op2 <= '0;
            end

            // A capture may coincide with a consume; the reload wins and the
            // register stays valid.
            if (capture) begin
                res_data  <= mcu_out;
                res_valid <= 1'b1;
            end else if (res_valid && host.res_ready) begin
                res_valid <= 1'b0;
            end

            if (retire) begin
                retired <= retired + 16'd1;
            end

            if (set_err) begin
                err    <= 1'b1;
                err_op <= mcu_op;
            end else if (state == S_HALT && clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcu_sequencer
//
// Directed bench for mcu_sequencer with a small behavioural mcu stand-in:
//   op 0  : mem[op2] = mem[op0] + mem[op1[3:0]]
//   op 7  : read, mcu_out = mem[op0]
//   op 8  : mem[op0] = op1
//   op >8 : invalid (mcu_op_err)
// mcu_out is combinational from the op ports; writes land on the edge that
// ends the issue cycle.
// -----------------------------------------------------------------------------
module tb_mcu_sequencer;

    localparam int OP_SZ  = 32;
    localparam int MEM_SZ = 4;
    localparam int DEPTH  = 4;
    localparam int IW     = 4 + 2 * MEM_SZ + OP_SZ;

    logic              clk;
    logic              reset;
    logic              run;
    logic              clr_err;
    logic              err;
    logic [3:0]        err_op;
    logic              busy;
    logic [15:0]       retired;
    logic [3:0]        mcu_op;
    logic [MEM_SZ-1:0] mcu_op0;
    logic [OP_SZ-1:0]  mcu_op1;
    logic [MEM_SZ-1:0] mcu_op2;
    logic [OP_SZ-1:0]  mcu_out;
    logic              mcu_op_err;

    int total = 0;
    int bad   = 0;

    mcu_sequencer_if #(.op_sz(OP_SZ), .mem_sz(MEM_SZ)) host_if ();

    mcu_sequencer #(
        .op_sz      (OP_SZ),
        .mem_sz     (MEM_SZ),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (host_if.slave),
        .run        (run),
        .clr_err    (clr_err),
        .err        (err),
        .err_op     (err_op),
        .busy       (busy),
        .retired    (retired),
        .mcu_op     (mcu_op),
        .mcu_op0    (mcu_op0),
        .mcu_op1    (mcu_op1),
        .mcu_op2    (mcu_op2),
        .mcu_out    (mcu_out),
        .mcu_op_err (mcu_op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mcu stand-in
    logic [OP_SZ-1:0] tb_mem [16] = '{default: '0};

    assign mcu_out    = tb_mem[mcu_op0];
    assign mcu_op_err = (mcu_op > 4'd8);

    always @(posedge clk) begin
        if (mcu_op == 4'd8) begin
            tb_mem[mcu_op0] <= mcu_op1;
        end else if (mcu_op == 4'd0) begin
            tb_mem[mcu_op2] <= tb_mem[mcu_op0] + tb_mem[mcu_op1[3:0]];
        end
    end

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] a,
                                         input logic [31:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    // Stream n NOP-reads, pushing whenever the sequencer is ready.
    task automatic push_nops(input int n);
        int pushed = 0;
        int guard  = 0;
        logic was_ready;
        while (pushed < n && guard < n + 1000) begin
            host_if.in_valid = 1'b1;
            host_if.in_instr = mk(4'd7, 4'd0, 32'd0, 4'd0);
            was_ready = host_if.in_ready;
            tick();
            if (was_ready) pushed++;
            guard++;
        end
        host_if.in_valid = 1'b0;
        check("push_count", 64'(pushed), 64'(n));
    endtask

    initial begin
        reset             = 1'b0;
        run               = 1'b0;
        clr_err           = 1'b0;
        host_if.in_valid  = 1'b0;
        host_if.in_instr  = '0;
        host_if.res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---------------- reset state ----------------
        check("rst_mcu_op",    64'(mcu_op),            64'd7);
        check("rst_mcu_op1",   64'(mcu_op1),           64'd0);
        check("rst_res_valid", 64'(host_if.res_valid), 64'd0);
        check("rst_retired",   64'(retired),           64'd0);
        check("rst_busy",      64'(busy),              64'd0);
        check("rst_in_ready",  64'(host_if.in_ready),  64'd1);

        // ---------------- write / write / add / read ----------------
        run               = 1'b1;
        host_if.res_ready = 1'b1;
        host_if.in_valid  = 1'b1;
        host_if.in_instr  = mk(4'd8, 4'd1, 32'd5, 4'd0);
        tick();
        host_if.in_instr  = mk(4'd8, 4'd2, 32'd7, 4'd0);
        tick();
        check("wr1_op",  64'(mcu_op),  64'd8);
        check("wr1_op0", 64'(mcu_op0), 64'd1);
        check("wr1_op1", 64'(mcu_op1), 64'd5);
        host_if.in_instr  = mk(4'd0, 4'd1, 32'd2, 4'd3);
        tick();
        host_if.in_instr  = mk(4'd7, 4'd3, 32'd0, 4'd0);
        tick();
        host_if.in_valid  = 1'b0;
        tick();
        check("rd3_issue_op0",   64'(mcu_op0),           64'd3);
        check("rd3_early_valid", 64'(host_if.res_valid), 64'd0);
        tick();
        check("rd3_valid",   64'(host_if.res_valid), 64'd1);
        check("rd3_data",    64'(host_if.res_data),  64'd12);
        check("rd3_retired", 64'(retired),           64'd4);
        check("rd3_busy",    64'(busy),              64'd0);
        check("rd3_nop",     64'(mcu_op),            64'd7);
        tick();
        check("rd3_consumed", 64'(host_if.res_valid), 64'd0);

        // ---------------- result backpressure ----------------
        host_if.res_ready = 1'b0;
        host_if.in_valid  = 1'b1;
        host_if.in_instr  = mk(4'd7, 4'd1, 32'd0, 4'd0);
        tick();
        host_if.in_instr  = mk(4'd7, 4'd2, 32'd0, 4'd0);
        tick();
        host_if.in_valid  = 1'b0;
        check("bp_rd1_op0", 64'(mcu_op0), 64'd1);
        tick();
        check("bp_first_valid",   64'(host_if.res_valid), 64'd1);
        check("bp_first_data",    64'(host_if.res_data),  64'd5);
        check("bp_first_retired", 64'(retired),           64'd5);
        check("bp_rd2_op0",       64'(mcu_op0),           64'd2);
        tick();
        check("bp_stall_data",    64'(host_if.res_data), 64'd5);
        check("bp_stall_op0",     64'(mcu_op0),          64'd2);
        check("bp_stall_retired", 64'(retired),          64'd5);
        check("bp_stall_busy",    64'(busy),             64'd1);
        host_if.res_ready = 1'b1;
        tick();
        check("bp_second_valid",   64'(host_if.res_valid), 64'd1);
        check("bp_second_data",    64'(host_if.res_data),  64'd7);
        check("bp_second_retired", 64'(retired),           64'd6);
        tick();
        check("bp_second_consumed", 64'(host_if.res_valid), 64'd0);

        // ---------------- invalid opcode ----------------
        host_if.in_valid = 1'b1;
        host_if.in_instr = mk(4'd12, 4'd0, 32'd0, 4'd0);
        tick();
        host_if.in_instr = mk(4'd8, 4'd5, 32'd9, 4'd0);
        tick();
        check("inv_issue_op", 64'(mcu_op), 64'd12);
        host_if.in_instr = mk(4'd7, 4'd5, 32'd0, 4'd0);
        tick();
        host_if.in_valid = 1'b0;
        check("inv_err",      64'(err),              64'd1);
        check("inv_err_op",   64'(err_op),           64'd12);
        check("inv_in_ready", 64'(host_if.in_ready), 64'd0);
        check("inv_nop",      64'(mcu_op),           64'd7);
        check("inv_retired",  64'(retired),          64'd6);
        tick();
        check("halt_hold_op",   64'(mcu_op), 64'd7);
        check("halt_hold_busy", 64'(busy),   64'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err",       64'(err),    64'd0);
        check("clr_err_op",    64'(err_op), 64'd12);
        check("clr_nop",       64'(mcu_op), 64'd7);
        tick();
        check("resume_wr_op",  64'(mcu_op),  64'd8);
        check("resume_wr_op0", 64'(mcu_op0), 64'd5);
        tick();
        tick();
        check("resume_rd_data",    64'(host_if.res_data),  64'd9);
        check("resume_rd_valid",   64'(host_if.res_valid), 64'd1);
        check("resume_rd_retired", 64'(retired),           64'd8);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_outside_err",  64'(err),  64'd0);
        check("clr_outside_busy", 64'(busy), 64'd0);

        // ---------------- full FIFO ----------------
        run = 1'b0;
        host_if.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            host_if.in_instr = mk(4'd8, 4'(8 + i), 32'(8'h80 + 16 * i), 4'd0);
            tick();
        end
        check("full_in_ready", 64'(host_if.in_ready), 64'd0);
        check("full_busy",     64'(busy),             64'd1);
        check("full_paused",   64'(mcu_op),           64'd7);
        host_if.in_instr = mk(4'd8, 4'd12, 32'hAA, 4'd0);
        tick();
        host_if.in_valid = 1'b0;
        check("full_refused_ready", 64'(host_if.in_ready), 64'd0);
        run = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("drain_op",  64'(mcu_op),  64'd8);
            check("drain_op0", 64'(mcu_op0), 64'(8 + i));
        end
        tick();
        check("drain_nop",     64'(mcu_op),     64'd7);
        check("drain_idle",    64'(busy),       64'd0);
        check("drain_retired", 64'(retired),    64'd12);
        check("drain_mem11",   64'(tb_mem[11]), 64'hB0);
        check("refused_mem12", 64'(tb_mem[12]), 64'd0);

        // ---------------- reset mid-stream ----------------
        run = 1'b0;
        host_if.in_valid = 1'b1;
        host_if.in_instr = mk(4'd8, 4'd0, 32'h11, 4'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            host_if.in_instr = mk(4'd8, 4'(13 + i), 32'h55, 4'd0);
            tick();
        end
        host_if.in_valid = 1'b0;
        run = 1'b1;
        tick();
        check("mid_exec_op",  64'(mcu_op),  64'd8);
        check("mid_exec_op0", 64'(mcu_op0), 64'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_op",        64'(mcu_op),            64'd7);
        check("mid_rst_op1",       64'(mcu_op1),           64'd0);
        check("mid_rst_retired",   64'(retired),           64'd0);
        check("mid_rst_busy",      64'(busy),              64'd0);
        check("mid_rst_in_ready",  64'(host_if.in_ready),  64'd1);
        check("mid_rst_res_valid", 64'(host_if.res_valid), 64'd0);
        check("mid_rst_res_data",  64'(host_if.res_data),  64'd0);
        check("mid_rst_err_op",    64'(err_op),            64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_op",    64'(mcu_op),     64'd7);
        check("post_rst_busy",  64'(busy),       64'd0);
        check("post_rst_mem0",  64'(tb_mem[0]),  64'd0);
        check("post_rst_mem13", 64'(tb_mem[13]), 64'd0);

        // ---------------- retired counter wrap ----------------
        push_nops(65535);
        wait_idle(100);
        check("wrap_ffff", 64'(retired), 64'hFFFF);
        push_nops(1);
        wait_idle(100);
        check("wrap_zero", 64'(retired), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
